// File: rtl/alarm_scheduler.sv
// alarm_scheduler
//   Holds NUM_ALARMS alarm slots and shares a single time comparator between
//   them. After each accepted second tick the slots are scanned one per cycle,
//   lowest index first; the first armed slot whose time equals the latched
//   tick time starts ringing. The ring / snooze / stop lifecycle of that slot
//   is sequenced here and drives the buzzer/LED enable.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   sec_tick        1-cycle pulse, cur_time just advanced by one second
//   cur_time        {hour[17:12], min[11:6], sec[5:0]}
//   wr_en/wr_idx/wr_time/wr_armed   slot load (illegal times rejected)
//   stop_key, snooze_key            debounced 1-cycle key pulses
//   alarming        ring enable (registered)
//   active_idx      slot that matched, meaningful in RING/SNOOZE
//   state           00 IDLE, 01 SCAN, 10 RING, 11 SNOOZE
//   slot_armed      armed bit of every slot
//   wr_err          1-cycle pulse after a rejected write

// One alarm slot: time plus armed bit, loaded only by validated writes.
module alarm_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [17:0] wr_time,
    input  logic        wr_armed,
    output logic [17:0] slot_time,
    output logic        armed
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_time <= '0;
            armed     <= 1'b0;
        end else if (we) begin
            slot_time <= wr_time;
            armed     <= wr_armed;
        end
    end
endmodule

module alarm_scheduler #(
    parameter  int NUM_ALARMS  = 4,
    parameter  int RING_SECS   = 60,
    parameter  int SNOOZE_SECS = 300,
    localparam int IDX_W       = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sec_tick,
    input  logic [17:0]           cur_time,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [17:0]           wr_time,
    input  logic                  wr_armed,
    input  logic                  stop_key,
    input  logic                  snooze_key,
    output logic                  alarming,
    output logic [IDX_W-1:0]      active_idx,
    output logic [1:0]            state,
    output logic [NUM_ALARMS-1:0] slot_armed,
    output logic                  wr_err
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SCAN   = 2'b01,
        S_RING   = 2'b10,
        S_SNOOZE = 2'b11
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ALARMS - 1);
    // ring_cnt+1 == RING_SECS is tested as ring_cnt == RING_SECS-1
    localparam logic [7:0]       RING_LAST = 8'(RING_SECS - 1);
    localparam logic [8:0]       SNZ_INIT  = 9'(SNOOZE_SECS);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             ptr_q, ptr_d;
    logic [IDX_W-1:0]             act_q, act_d;
    logic [17:0]                  cmp_q, cmp_d;
    logic [7:0]                   ring_q, ring_d;
    logic [8:0]                   snz_q, snz_d;
    logic                         alarming_q;
    logic                         wr_err_q;

    logic [NUM_ALARMS-1:0][17:0]  slot_time;
    logic [NUM_ALARMS-1:0]        slot_we;
    logic                         time_ok, wr_ok, abort, hit;

    assign time_ok = (wr_time[17:12] <= 6'd23) && (wr_time[11:6] <= 6'd59) &&
                     (wr_time[5:0] <= 6'd59);
    assign wr_ok   = wr_en && time_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            assign slot_we[gi] = wr_ok && (wr_idx == IDX_W'(gi));
            alarm_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .we        (slot_we[gi]),
                .wr_time   (wr_time),
                .wr_armed  (wr_armed),
                .slot_time (slot_time[gi]),
                .armed     (slot_armed[gi])
            );
        end
    endgenerate

    // Compare uses the registered slot contents, so a write landing on the
    // same edge is not seen by this comparison.
    assign hit = slot_armed[ptr_q] && (slot_time[ptr_q] == cmp_q);

    // Any accepted write to the slot being serviced cancels the alarm.
    assign abort = wr_ok && (wr_idx == act_q) &&
                   ((state_q == S_RING) || (state_q == S_SNOOZE));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        act_d   = act_q;
        cmp_d   = cmp_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        case (state_q)
            S_IDLE: begin
                if (sec_tick) begin
                    cmp_d   = cur_time;
                    ptr_d   = '0;
                    state_d = S_SCAN;
                end
            end
            // Ticks arriving here are dropped on purpose.
            S_SCAN: begin
                if (hit) begin
                    state_d = S_RING;
                    act_d   = ptr_q;
                    ring_d  = '0;
                end else if (ptr_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_RING: begin
                if (abort || stop_key) begin
                    state_d = S_IDLE;
                    ring_d  = '0;
                end else if (snooze_key) begin
                    state_d = S_SNOOZE;
                    snz_d   = SNZ_INIT;
                    ring_d  = '0;
                end else if (sec_tick) begin
                    if (ring_q == RING_LAST) begin
                        state_d = S_IDLE;
                        ring_d  = '0;
                    end else begin
                        ring_d = ring_q + 8'd1;
                    end
                end
            end
            S_SNOOZE: begin
                // snooze_key is deliberately ignored here
                if (abort || stop_key) begin
                    state_d = S_IDLE;
                    snz_d   = '0;
                end else if (sec_tick) begin
                    if (snz_q == 9'd1) begin
                        state_d = S_RING;
                        ring_d  = '0;
                        snz_d   = '0;
                    end else begin
                        snz_d = snz_q - 9'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            act_q      <= '0;
            cmp_q      <= '0;
            ring_q     <= '0;
            snz_q      <= '0;
            alarming_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            act_q      <= act_d;
            cmp_q      <= cmp_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            alarming_q <= (state_d == S_RING);
            wr_err_q   <= wr_en && !time_ok;
        end
    end

    assign alarming   = alarming_q;
    assign active_idx = act_q;
    assign state      = state_q;
    assign wr_err     = wr_err_q;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: the driver advances a behavioural
// model each cycle and queues the outputs it predicts; the monitor pops and
// compares at every falling edge.
module tb_alarm_scheduler;
    localparam int NA = 4;
    localparam int RS = 3;
    localparam int SS = 2;
    localparam int IW = $clog2(NA);
    localparam int M_IDLE = 0, M_SCAN = 1, M_RING = 2, M_SNOOZE = 3;

    logic          clk = 1'b0, rst_n = 1'b0, sec_tick = 1'b0, wr_en = 1'b0;
    logic          wr_armed = 1'b0, stop_key = 1'b0, snooze_key = 1'b0;
    logic [17:0]   cur_time = '0, wr_time = '0;
    logic [IW-1:0] wr_idx = '0;
    logic          alarming, wr_err;
    logic [IW-1:0] active_idx;
    logic [1:0]    state;
    logic [NA-1:0] slot_armed;

    alarm_scheduler #(.NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .cur_time(cur_time),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time), .wr_armed(wr_armed),
        .stop_key(stop_key), .snooze_key(snooze_key), .alarming(alarming),
        .active_idx(active_idx), .state(state), .slot_armed(slot_armed),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          alarming;
        int          idx;
        int          st;
        bit [NA-1:0] armed;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;

    // ---------------- reference model ----------------
    int m_mode, m_ptr, m_cmp, m_ring, m_snz, m_act;
    int m_time[NA];
    bit m_arm[NA];
    bit m_err;

    function automatic int mk(int h, int m, int s);
        return h * 4096 + m * 64 + s;
    endfunction

    function automatic bit legal(int t);
        return (t / 4096) < 24 && ((t / 64) % 64) < 60 && (t % 64) < 60;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ptr = 0; m_cmp = 0; m_ring = 0; m_snz = 0; m_act = 0;
        m_err = 0;
        for (int i = 0; i < NA; i++) begin
            m_time[i] = 0;
            m_arm[i]  = 0;
        end
    endtask

    // Advance the model over one rising edge using the inputs the DUT sampled.
    task automatic model_step();
        int ot[NA];
        bit oa[NA];
        bit ok, abort;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ot    = m_time;
        oa    = m_arm;
        ok    = wr_en && legal(int'(wr_time));
        m_err = wr_en && !ok;
        abort = ok && int'(wr_idx) == m_act && (m_mode == M_RING || m_mode == M_SNOOZE);
        if (ok && int'(wr_idx) < NA) begin
            m_time[int'(wr_idx)] = int'(wr_time);
            m_arm[int'(wr_idx)]  = wr_armed;
        end
        case (m_mode)
            M_IDLE: if (sec_tick) begin
                m_cmp = int'(cur_time); m_ptr = 0; m_mode = M_SCAN;
            end
            M_SCAN: begin
                if (oa[m_ptr] && ot[m_ptr] == m_cmp) begin
                    m_mode = M_RING; m_act = m_ptr; m_ring = 0;
                end else if (m_ptr == NA - 1) m_mode = M_IDLE;
                else m_ptr++;
            end
            M_RING: begin
                if (abort || stop_key) m_mode = M_IDLE;
                else if (snooze_key) begin m_mode = M_SNOOZE; m_snz = SS; end
                else if (sec_tick) begin
                    m_ring++;
                    if (m_ring == RS) m_mode = M_IDLE;
                end
            end
            default: begin
                if (abort || stop_key) m_mode = M_IDLE;
                else if (sec_tick) begin
                    m_snz--;
                    if (m_snz == 0) begin m_mode = M_RING; m_ring = 0; end
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    bit nx_rst = 0, nx_tick = 0, nx_we = 0, nx_wa = 0, nx_stop = 0, nx_snz = 0;
    int nx_cur = 0, nx_wt = 0, nx_wi = 0;

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        rst_n      = nx_rst;
        sec_tick   = nx_tick;
        cur_time   = 18'(nx_cur);
        wr_en      = nx_we;
        wr_idx     = IW'(nx_wi);
        wr_time    = 18'(nx_wt);
        wr_armed   = nx_wa;
        stop_key   = nx_stop;
        snooze_key = nx_snz;
        if (!nx_rst) model_reset();   // asynchronous: outputs clear right away
        e.alarming = (m_mode == M_RING);
        e.idx      = m_act;
        e.st       = m_mode;
        for (int i = 0; i < NA; i++) e.armed[i] = m_arm[i];
        e.err      = m_err;
        q.push_back(e);
        nx_tick = 0; nx_we = 0; nx_stop = 0; nx_snz = 0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic wr(int i, int t, bit a);
        nx_we = 1; nx_wi = i; nx_wt = t; nx_wa = a;
        step();
    endtask

    task automatic tick(int t);
        nx_tick = 1; nx_cur = t;
        step();
    endtask

    // ---------------- monitor ----------------
    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("alarming", int'(alarming), int'(e.alarming));
            chk("state", int'(state), e.st);
            chk("slot_armed", int'(slot_armed), int'(e.armed));
            chk("wr_err", int'(wr_err), int'(e.err));
            if (e.st == M_RING || e.st == M_SNOOZE)
                chk("active_idx", int'(active_idx), e.idx);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        idle(2);                      // reset state
        nx_rst = 1;
        idle(2);

        // single match on slot 2, then stop
        wr(2, mk(7, 30, 0), 1);
        idle(2);
        tick(mk(7, 30, 0));
        idle(6);
        nx_stop = 1; step();
        idle(2);

        // lowest of two matches wins, disarmed slot 0 ignored; ring timeout
        wr(1, mk(6, 0, 0), 1);
        wr(3, mk(6, 0, 0), 1);
        wr(0, mk(6, 0, 0), 0);
        tick(mk(6, 0, 0));
        idle(6);
        repeat (3) begin tick(0); idle(3); end

        // snooze, re-ring after SS ticks, stop+snooze together
        tick(mk(6, 0, 0));
        idle(5);
        nx_snz = 1; step();
        idle(2);
        tick(0); idle(2);
        tick(0); idle(2);
        nx_stop = 1; nx_snz = 1; step();
        idle(2);

        // illegal write, then disarm of the ringing slot
        wr(1, mk(24, 0, 0), 1);
        wr(2, mk(5, 60, 0), 1);
        idle(1);
        tick(mk(6, 0, 0));
        idle(5);
        wr(1, mk(6, 0, 0), 0);
        idle(2);

        // slot 3 rings, reset mid-ring
        tick(mk(6, 0, 0));
        idle(6);
        nx_rst = 0; step(); step();
        nx_rst = 1; idle(2);

        // second tick during SCAN is dropped
        wr(0, mk(1, 2, 3), 1);
        tick(mk(1, 2, 4));
        tick(mk(1, 2, 3));
        idle(6);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                nx_tick = 1;
                if ($urandom_range(0, 1) == 0) nx_cur = m_time[$urandom_range(0, NA - 1)];
                else nx_cur = mk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            end
            if ($urandom_range(0, 9) == 0) begin
                nx_we = 1;
                nx_wi = $urandom_range(0, NA - 1);
                nx_wa = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0: nx_wt = mk($urandom_range(24, 63), $urandom_range(0, 59), $urandom_range(0, 59));
                    1: nx_wt = mk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(60, 63));
                    default: nx_wt = mk($urandom_range(0, 23), $urandom_range(0, 3), $urandom_range(0, 3));
                endcase
            end
            nx_stop = ($urandom_range(0, 29) == 0);
            nx_snz  = ($urandom_range(0, 14) == 0);
            nx_rst  = ($urandom_range(0, 499) != 0);
            step();
            nx_rst = 1;
        end
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
